core_wb_bridge: RTL and testbench

CORE_WB_BRIDGE -- requirements
Module: core_wb_bridge

---
 rtl/core_wb_bridge.sv | 142 ++++++++++++++
 tb/tb_core_wb_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_bridge.sv
// Core request/response to Wishbone classic master bridge.
// One transfer in flight; misaligned accesses and bus timeouts return an error response.
module core_wb_bridge #(
  parameter int unsigned WB_AD_WIDTH    = 32,
  parameter int unsigned WB_DAT_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      core_req_valid_i,
  output logic                      core_req_ready_o,
  input  logic [WB_AD_WIDTH-1:0]    core_req_addr_i,
  input  logic [WB_DAT_WIDTH-1:0]   core_req_wdata_i,
  input  logic [WB_DAT_WIDTH/8-1:0] core_req_sel_i,
  input  logic                      core_req_we_i,

  output logic                      core_rsp_valid_o,
  input  logic                      core_rsp_ready_i,
  output logic [WB_DAT_WIDTH-1:0]   core_rsp_rdata_o,
  output logic                      core_rsp_err_o,

  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [WB_AD_WIDTH-1:0]    wbm_addr_o,
  output logic [WB_DAT_WIDTH-1:0]   wbm_wdata_o,
  output logic [WB_DAT_WIDTH/8-1:0] wbm_sel_o,
  input  logic [WB_DAT_WIDTH-1:0]   wbm_rdata_i,
  input  logic                      wbm_ack_i
);

  localparam int unsigned SelWidth    = WB_DAT_WIDTH / 8;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e                   state_q, state_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [WB_AD_WIDTH-1:0]   addr_q, addr_d;
  logic [WB_DAT_WIDTH-1:0]  wdata_q, wdata_d;
  logic [SelWidth-1:0]      sel_q, sel_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [WB_DAT_WIDTH-1:0]  rdata_q, rdata_d;
  logic                     err_q, err_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (core_req_valid_i) begin
          we_d    = core_req_we_i;
          addr_d  = core_req_addr_i;
          wdata_d = core_req_wdata_i;
          sel_d   = core_req_sel_i;
          if (core_req_addr_i[1:0] != 2'b00) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = StBus;
            cyc_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      StBus: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (wbm_ack_i) begin
          state_d = StResp;
          cyc_d   = 1'b0;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : wbm_rdata_i;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResp;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        if (core_rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign core_req_ready_o = (state_q == StIdle);
  assign core_rsp_valid_o = (state_q == StResp);
  assign core_rsp_rdata_o = rdata_q;
  assign core_rsp_err_o   = err_q;

  // cyc and stb share one register, so cyc can never be high without stb.
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_addr_o  = addr_q;
  assign wbm_wdata_o = wdata_q;
  assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_core_wb_bridge.sv
// Randomized self-checking bench for core_wb_bridge against a transaction-level model
// (expected bus-cycle count, latency and response derived per request).
module tb_core_wb_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req_valid_i;
  logic          core_req_ready_o;
  logic [AW-1:0] core_req_addr_i;
  logic [DW-1:0] core_req_wdata_i;
  logic [SW-1:0] core_req_sel_i;
  logic          core_req_we_i;
  logic          core_rsp_valid_o;
  logic          core_rsp_ready_i;
  logic [DW-1:0] core_rsp_rdata_o;
  logic          core_rsp_err_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [AW-1:0] wbm_addr_o;
  logic [DW-1:0] wbm_wdata_o;
  logic [SW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_rdata_i;
  logic          wbm_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  core_wb_bridge #(
    .WB_AD_WIDTH    (AW),
    .WB_DAT_WIDTH   (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .core_req_valid_i (core_req_valid_i),
    .core_req_ready_o (core_req_ready_o),
    .core_req_addr_i  (core_req_addr_i),
    .core_req_wdata_i (core_req_wdata_i),
    .core_req_sel_i   (core_req_sel_i),
    .core_req_we_i    (core_req_we_i),
    .core_rsp_valid_o (core_rsp_valid_o),
    .core_rsp_ready_i (core_rsp_ready_i),
    .core_rsp_rdata_o (core_rsp_rdata_o),
    .core_rsp_err_o   (core_rsp_err_o),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_we_o         (wbm_we_o),
    .wbm_addr_o       (wbm_addr_o),
    .wbm_wdata_o      (wbm_wdata_o),
    .wbm_sel_o        (wbm_sel_o),
    .wbm_rdata_i      (wbm_rdata_i),
    .wbm_ack_i        (wbm_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one request, act as a slave that acks after `waits` wait states, then
  // hold the response for `hold` cycles before consuming it.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic we, input int waits,
                         input logic [31:0] sdata, input int hold);
    bit          misal   = (addr[1:0] != 2'b00);
    bit          tmo     = !misal && (waits >= int'(TO));
    int          exp_cyc = misal ? 0 : (tmo ? int'(TO) : waits + 1);
    int          exp_lat = misal ? 1 : exp_cyc + 1;
    logic        exp_err = misal || tmo;
    logic [31:0] exp_rd  = (exp_err || we) ? 32'h0 : sdata;
    int          cyc_n   = 0;
    int          lat     = 0;
    bit          got_rsp = 1'b0;

    check_eq("req_ready_idle", core_req_ready_o, 1);
    core_req_valid_i = 1'b1;
    core_req_addr_i  = addr;
    core_req_wdata_i = wdata;
    core_req_sel_i   = sel;
    core_req_we_i    = we;
    @(posedge clk);
    @(negedge clk);
    core_req_valid_i = 1'b0;
    core_req_addr_i  = $urandom;
    core_req_wdata_i = $urandom;
    core_req_sel_i   = 4'($urandom);
    core_req_we_i    = 1'($urandom);

    for (int n = 1; n <= 60 && !got_rsp; n++) begin
      check_eq("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
      if (core_rsp_valid_o) begin
        got_rsp = 1'b1;
        lat     = n;
      end else begin
        check_eq("req_ready_busy", core_req_ready_o, 0);
        if (wbm_cyc_o) begin
          cyc_n++;
          check_eq("bus_addr", wbm_addr_o, addr);
          check_eq("bus_we_sel_wdata", {wbm_we_o, wbm_sel_o, wbm_wdata_o}, {we, sel, wdata});
          wbm_ack_i   = (cyc_n == waits + 1);
          wbm_rdata_i = wbm_ack_i ? sdata : $urandom;
        end else begin
          wbm_ack_i = 1'b0;
        end
        @(negedge clk);
      end
    end
    check_eq("rsp_arrived", got_rsp, 1);
    check_eq("rsp_latency", lat, exp_lat);
    check_eq("bus_cycles", cyc_n, exp_cyc);
    check_eq("rsp_err", core_rsp_err_o, exp_err);
    check_eq("rsp_rdata", core_rsp_rdata_o, exp_rd);

    // Backpressure: stray acks and new requests must not disturb a pending response.
    for (int h = 0; h < hold; h++) begin
      wbm_ack_i        = 1'($urandom);
      wbm_rdata_i      = $urandom;
      core_req_valid_i = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_valid", core_rsp_valid_o, 1);
      check_eq("hold_err", core_rsp_err_o, exp_err);
      check_eq("hold_rdata", core_rsp_rdata_o, exp_rd);
      check_eq("hold_req_ready", core_req_ready_o, 0);
      check_eq("hold_cyc", wbm_cyc_o, 0);
    end

    // Handshake with a new aligned request offered in the same cycle: must not be taken.
    wbm_ack_i        = 1'b0;
    core_rsp_ready_i = 1'b1;
    core_req_valid_i = 1'b1;
    core_req_addr_i  = 32'h0000_1000;
    @(posedge clk);
    @(negedge clk);
    core_rsp_ready_i = 1'b0;
    core_req_valid_i = 1'b0;
    check_eq("post_rsp_valid", core_rsp_valid_o, 0);
    check_eq("post_req_ready", core_req_ready_o, 1);
    check_eq("no_bypass_cyc", wbm_cyc_o, 0);
  endtask

  task automatic reset_mid_bus();
    core_req_valid_i = 1'b1;
    core_req_addr_i  = 32'h0200_0100;
    core_req_we_i    = 1'b0;
    core_req_sel_i   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    core_req_valid_i = 1'b0;
    check_eq("rst_pre_cyc", wbm_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_cyc", wbm_cyc_o, 0);
    check_eq("rst_async_stb", wbm_stb_o, 0);
    check_eq("rst_async_req_ready", core_req_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wbm_ack_i = 1'($urandom);
      @(negedge clk);
      check_eq("rst_after_rsp_valid", core_rsp_valid_o, 0);
      check_eq("rst_after_cyc", wbm_cyc_o, 0);
    end
    wbm_ack_i = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    core_req_valid_i = 1'b0;
    core_req_addr_i  = '0;
    core_req_wdata_i = '0;
    core_req_sel_i   = '0;
    core_req_we_i    = 1'b0;
    core_rsp_ready_i = 1'b0;
    wbm_rdata_i      = '0;
    wbm_ack_i        = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_bus_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
    check_eq("reset_bus_addr", wbm_addr_o, 0);
    check_eq("reset_bus_data_sel", {wbm_wdata_o, wbm_sel_o}, 0);
    check_eq("reset_rsp", {core_rsp_valid_o, core_rsp_err_o, core_rsp_rdata_o}, 0);
    check_eq("reset_req_ready", core_req_ready_o, 1);
    rst = 1'b0;
    @(negedge clk);

    run_txn(32'h0200_BFF8, 32'h0, 4'hF, 1'b0, 0, 32'h0000_1234, 0);
    run_txn(32'h0200_4000, 32'hDEAD_BEEF, 4'hF, 1'b1, 3, 32'h5555_AAAA, 0);
    run_txn(32'h0200_4004, 32'h0, 4'hF, 1'b0, 50, 32'h7777_7777, 3);
    run_txn(32'h0200_0002, 32'h1111_2222, 4'h3, 1'b0, 0, 32'h9999_9999, 1);
    run_txn(32'h0200_0010, 32'h0, 4'hF, 1'b0, 1, 32'hCAFE_F00D, 5);
    run_txn(32'h0200_0020, 32'h0, 4'hF, 1'b0, int'(TO) - 1, 32'h0BAD_F00D, 0);
    reset_mid_bus();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      run_txn(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 10), $urandom,
              $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
